// File: rtl/draw_donkey_intro_pkg.sv
// Shared constants and types for the Donkey intro overlay: VGA timing, sprite, map and sprite image.
package draw_donkey_intro_pkg;

  localparam int unsigned VER_PIXELS = 768;

  localparam int unsigned SPRITE_W = 48;
  localparam int unsigned SPRITE_H = 32;
  localparam logic [11:0] TRANSPARENT = 12'hF0F;

  typedef enum logic {
    FRM_CLIMB = 1'b0,
    FRM_JUMP  = 1'b1
  } donkey_frame_t;

  localparam int unsigned LADDER_X      = 484;
  localparam int unsigned LADDER_BOTTOM = VER_PIXELS - 64;
  localparam int unsigned LADDER_SEGS   = 12;
  localparam int unsigned SEG_H         = 32;
  localparam logic [11:0] BG_COLOR      = 12'h000;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  // Sprite image, two 48x32 frames back to back; every 16th word (low nibble 7) is see-through.
  function automatic logic [11:0] donkey_pixel(input logic [11:0] addr);
    if (addr[3:0] == 4'h7) return TRANSPARENT;
    return addr ^ 12'h0F0;
  endfunction

endpackage

// File: rtl/draw_donkey_intro_rom.sv
// Donkey sprite image ROM with a one-cycle registered read.
module draw_donkey_intro_rom
  import draw_donkey_intro_pkg::*;
(
  input  logic        clk,
  input  logic [11:0] addr,
  output logic [11:0] rgb
);

  always_ff @(posedge clk) begin
    rgb <= donkey_pixel(addr);
  end

endmodule

// File: rtl/draw_donkey_intro.sv
// Donkey intro overlay: draws the Donkey sprite over the VGA stream with a fixed 2-cycle latency.
// Build option: define LADDER_ERASE_EN to blank ladder segments Donkey has already climbed.
module draw_donkey_intro
  import draw_donkey_intro_pkg::*;
#(
  parameter int unsigned SpriteW = SPRITE_W,
  parameter int unsigned SpriteH = SPRITE_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        animation,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [3:0]  counter,
  input  logic [3:0]  ctl,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  localparam logic [11:0] SprW     = 12'(SpriteW);
  localparam logic [11:0] SprH     = 12'(SpriteH);
  localparam logic [11:0] FrameOff = 12'(SpriteW * SpriteH);

  vga_t          vga_in, s1_q, out_d, out_q;
  logic          vblnk_d, latch, anim_s, in_box, draw_q, erase_d, erase_q;
  logic [11:0]   x_s, y_s, dx, dy, rom_addr, pix;
  logic [3:0]    ctl_s;
  donkey_frame_t frame;

  assign vga_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in};
  assign latch  = vblnk_in && !vblnk_d;

  assign dx     = {1'b0, hcount_in} - x_s;
  assign dy     = {1'b0, vcount_in} - y_s;
  assign in_box = ({1'b0, hcount_in} >= x_s) && ({1'b0, vcount_in} >= y_s) &&
                  (dx < SprW) && (dy < SprH);
  assign frame    = (ctl_s == 4'd0) ? FRM_CLIMB : FRM_JUMP;
  assign rom_addr = ((frame == FRM_JUMP) ? FrameOff : 12'd0) + dy * SprW + dx;

  draw_donkey_intro_rom u_donkey_rom (
    .clk  (clk),
    .addr (rom_addr),
    .rgb  (pix)
  );

`ifdef LADDER_ERASE_EN
  localparam logic [10:0] ColL = 11'(LADDER_X);
  localparam logic [10:0] ColR = 11'(LADDER_X + SEG_H);
  localparam logic [10:0] RowT = 11'(LADDER_BOTTOM - SEG_H * LADDER_SEGS);
  localparam logic [10:0] RowB = 11'(LADDER_BOTTOM);

  logic [3:0] counter_s;
  logic [5:0] seg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_s <= '0;
    end else if (latch) begin
      counter_s <= counter;
    end
  end

  // Segment 0 is the bottom one; erasing stops with the intro so later frames are untouched.
  assign seg     = 6'((RowB - 11'd1 - vcount_in) >> 5);
  assign erase_d = anim_s && (hcount_in >= ColL) && (hcount_in < ColR) &&
                   (vcount_in >= RowT) && (vcount_in < RowB) && (seg < {2'b00, counter_s});
`else
  logic unused_counter;
  assign unused_counter = ^counter;
  assign erase_d        = 1'b0;
`endif

  always_comb begin
    out_d = s1_q;
    if (s1_q.hblnk || s1_q.vblnk) begin
      out_d.rgb = 12'h000;
    end else if (draw_q && (pix != TRANSPARENT)) begin
      out_d.rgb = pix;
    end else if (erase_q) begin
      out_d.rgb = BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vblnk_d <= 1'b0;
      anim_s  <= 1'b0;
      x_s     <= '0;
      y_s     <= '0;
      ctl_s   <= '0;
      s1_q    <= '0;
      draw_q  <= 1'b0;
      erase_q <= 1'b0;
      out_q   <= '0;
    end else begin
      vblnk_d <= vblnk_in;
      if (latch) begin
        anim_s <= animation;
        x_s    <= xpos;
        y_s    <= ypos;
        ctl_s  <= ctl;
      end
      s1_q    <= vga_in;
      draw_q  <= anim_s && in_box;
      erase_q <= erase_d;
      out_q   <= out_d;
    end
  end

  assign hcount_out = out_q.hcount;
  assign vcount_out = out_q.vcount;
  assign hsync_out  = out_q.hsync;
  assign hblnk_out  = out_q.hblnk;
  assign vsync_out  = out_q.vsync;
  assign vblnk_out  = out_q.vblnk;
  assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_draw_donkey_intro.sv
// Randomized bench for draw_donkey_intro against a frame-level behavioural model.
module tb_draw_donkey_intro;

`ifdef LADDER_ERASE_EN
  localparam bit Erase = 1'b1;
`else
  localparam bit Erase = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        animation = 1'b0;
  logic [11:0] xpos = '0, ypos = '0;
  logic [3:0]  counter = '0, ctl = '0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [37:0] dut_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_donkey_intro dut (
    .clk        (clk),
    .rst        (rst),
    .animation  (animation),
    .xpos       (xpos),
    .ypos       (ypos),
    .counter    (counter),
    .ctl        (ctl),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .hblnk_in   (hblnk_in),
    .vsync_in   (vsync_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .hblnk_out  (hblnk_out),
    .vsync_out  (vsync_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  assign dut_vec = {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};

  // Sprite image: frame-major 48x32 words, word 16k+7 transparent, others are index ^ 0x0F0.
  function automatic logic [11:0] rom_word(input int a);
    if (a % 16 == 7) return 12'hF0F;
    return 12'(a) ^ 12'h0F0;
  endfunction

  // Final output of one pixel given the values latched at the last vblank start.
  function automatic logic [37:0] model(input logic [10:0] hc, input logic [10:0] vc,
                                        input logic hs, input logic hb, input logic vs,
                                        input logic vb, input logic [11:0] c, input int anim,
                                        input int x, input int y, input int cnt, input int fr);
    int dx, dy;
    logic [11:0] r, w;
    dx = int'(hc) - x;
    dy = int'(vc) - y;
    r  = c;
    w  = 12'hF0F;
    if (dx >= 0 && dx < 48 && dy >= 0 && dy < 32) w = rom_word(fr * 1536 + dy * 48 + dx);
    if (hb || vb) r = 12'h000;
    else if (anim != 0 && w != 12'hF0F) r = w;
    else if (Erase && anim != 0 && hc >= 484 && hc < 516 && vc >= 320 && vc < 704 &&
             (703 - int'(vc)) / 32 < cnt) r = 12'h000;
    return {hc, vc, hs, hb, vs, vb, r};
  endfunction

  int          sh_anim = 0, sh_x = 0, sh_y = 0, sh_cnt = 0, sh_fr = 0;
  bit          vb_d = 1'b0;
  bit          started = 1'b0;
  logic [37:0] p1 = '0, p2 = '0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst) begin
      p1 <= '0;
      p2 <= '0;
      vb_d <= 1'b0;
      sh_anim <= 0; sh_x <= 0; sh_y <= 0; sh_cnt <= 0; sh_fr <= 0;
    end else begin
      p2 <= p1;
      p1 <= model(hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
                  sh_anim, sh_x, sh_y, sh_cnt, sh_fr);
      vb_d <= vblnk_in;
      if (vblnk_in && !vb_d) begin
        sh_anim <= int'(animation);
        sh_x    <= int'(xpos);
        sh_y    <= int'(ypos);
        sh_cnt  <= int'(counter);
        sh_fr   <= (ctl != 4'd0) ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (dut_vec !== p2) begin
        errors++;
        $display("FAIL pipe @%0t: dut=%h model=%h", $time, dut_vec, p2);
      end
    end
  end

  task automatic drive_random(input int lx, input int ly);
    int sel = $urandom_range(2, 0);
    int hc, vc;
    if (sel == 0) begin
      hc = lx + $urandom_range(52, 0) - 2;
      vc = ly + $urandom_range(35, 0) - 2;
    end else if (sel == 1) begin
      hc = 478 + $urandom_range(44, 0);
      vc = 310 + $urandom_range(400, 0);
    end else begin
      hc = $urandom_range(2047, 0);
      vc = $urandom_range(2047, 0);
    end
    hcount_in = 11'(hc);
    vcount_in = 11'(vc);
    hblnk_in  = ($urandom_range(7, 0) == 0);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    rgb_in    = 12'($urandom);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h expected all zero", name, dut_vec);
    end
  endtask

  // Entered at a negedge; holds reset for 5 clock edges with live stimulus.
  task automatic reset_pulse(input int lx, input int ly);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_random(lx, ly);
      vblnk_in = 1'b0;
      @(negedge clk);
      check_zero("reset_zero");
    end
    rst = 1'b1;
  endtask

  task automatic check_pix(input string name, input int hc, input int vc, input logic [11:0] c,
                           input logic hb, input logic [11:0] exp);
    @(negedge clk);
    hcount_in = 11'(hc);
    vcount_in = 11'(vc);
    rgb_in    = c;
    hblnk_in  = hb;
    vblnk_in  = 1'b0;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    @(negedge clk);
    hcount_in = '0;
    vcount_in = '0;
    rgb_in    = '0;
    hblnk_in  = 1'b0;
    @(negedge clk);
    checks++;
    if (rgb_out !== exp) begin
      errors++;
      $display("FAIL %s: rgb_out=%h expected=%h", name, rgb_out, exp);
    end
  endtask

  // Vblank rises with the wanted values, then scrambles them so only the edge can latch.
  task automatic new_frame(input logic anim, input int x, input int y, input int cnt,
                           input int c);
    @(negedge clk);
    vblnk_in  = 1'b1;
    hblnk_in  = 1'b0;
    animation = anim;
    xpos      = 12'(x);
    ypos      = 12'(y);
    counter   = 4'(cnt);
    ctl       = 4'(c);
    repeat (3) begin
      @(negedge clk);
      animation = ~anim;
      xpos      = ~12'(x);
      ypos      = ~12'(y);
      counter   = ~4'(cnt);
      ctl       = ~4'(c);
      rgb_in    = 12'($urandom);
    end
    @(negedge clk);
    vblnk_in = 1'b0;
  endtask

  task automatic random_frame(input bit do_reset);
    int lx, ly, mid;
    lx  = ($urandom_range(7, 0) == 0) ? $urandom_range(4095, 0) : $urandom_range(1100, 0);
    ly  = $urandom_range(780, 0);
    mid = $urandom_range(200, 20);
    @(negedge clk);
    drive_random(lx, ly);
    vblnk_in  = 1'b1;
    animation = ($urandom_range(3, 0) != 0);
    xpos      = 12'(lx);
    ypos      = 12'(ly);
    counter   = 4'($urandom);
    ctl       = ($urandom_range(1, 0) == 0) ? 4'd0 : 4'($urandom);
    repeat (5) begin
      @(negedge clk);
      drive_random(lx, ly);
      xpos = 12'($urandom);
      counter = 4'($urandom);
    end
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (c == mid) begin
        animation = 1'($urandom);
        xpos      = 12'($urandom);
        ypos      = 12'($urandom);
        counter   = 4'($urandom);
        ctl       = 4'($urandom);
      end
      if (do_reset && c == 100) reset_pulse(lx, ly);
      drive_random(lx, ly);
      vblnk_in = 1'b0;
    end
  endtask

  initial begin
    reset_pulse(0, 0);
    check_pix("pass_after_reset", 484, 400, 12'h3C3, 1'b0, 12'h3C3);

    new_frame(1'b1, 484, 400, 3, 0);
    check_pix("sprite_top_left", 484, 400, 12'h123, 1'b0, 12'h0F0);
    check_pix("sprite_bottom_right", 531, 431, 12'h123, 1'b0, 12'h50F);
    check_pix("left_of_sprite", 483, 400, 12'hABC, 1'b0, 12'hABC);
    check_pix("right_of_sprite", 532, 400, 12'h456, 1'b0, 12'h456);
    check_pix("transparent", 491, 400, 12'h789, 1'b0, 12'h789);
    check_pix("hblank", 484, 400, 12'hFFF, 1'b1, 12'h000);
    check_pix("ladder_bottom_row", 490, 703, 12'h111, 1'b0, Erase ? 12'h000 : 12'h111);
    check_pix("ladder_seg2_top", 490, 608, 12'h111, 1'b0, Erase ? 12'h000 : 12'h111);
    check_pix("ladder_above", 490, 607, 12'h222, 1'b0, 12'h222);
    check_pix("ladder_right", 516, 650, 12'h333, 1'b0, 12'h333);

    xpos = 12'd500;
    check_pix("latch_hold_in", 485, 400, 12'h321, 1'b0, 12'h0F1);
    check_pix("latch_hold_out", 532, 400, 12'h456, 1'b0, 12'h456);

    new_frame(1'b1, 500, 400, 3, 1);
    check_pix("jump_frame", 500, 400, 12'h000, 1'b0, 12'h6F0);
    check_pix("moved_sprite", 532, 400, 12'h456, 1'b0, 12'h6D0);
    check_pix("moved_vacated", 485, 400, 12'h321, 1'b0, 12'h321);

    animation = 1'b0;
    check_pix("anim_fall_hold", 500, 400, 12'h0AA, 1'b0, 12'h6F0);
    new_frame(1'b0, 500, 400, 3, 1);
    check_pix("intro_over", 500, 400, 12'h5A5, 1'b0, 12'h5A5);
    check_pix("intro_over_ladder", 490, 703, 12'h111, 1'b0, 12'h111);

    for (int f = 0; f < 30; f++) random_frame(f == 12);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
